// File: rtl/bmp_load_ctrl_pkg.sv
// Shared constants for the BMP load controller: FSM encodings, error codes,
// header byte offsets and the header byte-lane helpers.
package bmp_load_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_SIG     = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_SIZE    = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;
  localparam logic [2:0] ERR_OFFSET  = 3'd5;

  localparam int unsigned HDR_LEN    = 32'd54;
  localparam int unsigned OFF_SIG    = 32'd0;
  localparam int unsigned OFF_FSIZE  = 32'd2;
  localparam int unsigned OFF_DOFF   = 32'd10;
  localparam int unsigned OFF_WIDTH  = 32'd18;
  localparam int unsigned OFF_HEIGHT = 32'd22;

  localparam logic [7:0] SIG_B0 = 8'h42;
  localparam logic [7:0] SIG_B1 = 8'h4D;

  function automatic logic in_field(logic [31:0] idx, int unsigned off, int unsigned len);
    return (idx >= off) && (idx < (off + len));
  endfunction

  // Little-endian: byte k of a field lands at bit 8k.
  function automatic logic [4:0] lane_pos(logic [1:0] idx_lo, logic [1:0] off_lo);
    logic [1:0] rel;
    rel = idx_lo - off_lo;
    return {rel, 3'b000};
  endfunction

endpackage

// File: rtl/bmp_load_ctrl_hdr_capture.sv
// Header shadow: snoops ROM bytes by index and assembles the signature
// and the four little-endian 32-bit header fields.
module bmp_hdr_capture
  import bmp_load_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  stb_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [7:0]            byte_i,
  output logic [15:0]           sig_o,
  output logic [31:0]           file_size_o,
  output logic [31:0]           data_offset_o,
  output logic [31:0]           width_o,
  output logic [31:0]           height_o
);

  logic [31:0] idx_s;
  logic [15:0] sig_q, sig_d;
  logic [31:0] fsize_q, fsize_d;
  logic [31:0] doff_q, doff_d;
  logic [31:0] width_q, width_d;
  logic [31:0] height_q, height_d;

  assign idx_s = 32'(idx_i);

  // Next-state for the header shadow: sync clear wins over a byte strobe.
  always_comb begin
    sig_d    = sig_q;
    fsize_d  = fsize_q;
    doff_d   = doff_q;
    width_d  = width_q;
    height_d = height_q;
    if (clr_i) begin
      sig_d    = 16'd0;
      fsize_d  = 32'd0;
      doff_d   = 32'd0;
      width_d  = 32'd0;
      height_d = 32'd0;
    end else if (stb_i && in_field(idx_s, OFF_SIG, 32'd2)) begin
      sig_d[{idx_s[0], 3'b000} +: 8] = byte_i;
    end else if (stb_i && in_field(idx_s, OFF_FSIZE, 32'd4)) begin
      fsize_d[lane_pos(idx_s[1:0], 2'(OFF_FSIZE)) +: 8] = byte_i;
    end else if (stb_i && in_field(idx_s, OFF_DOFF, 32'd4)) begin
      doff_d[lane_pos(idx_s[1:0], 2'(OFF_DOFF)) +: 8] = byte_i;
    end else if (stb_i && in_field(idx_s, OFF_WIDTH, 32'd4)) begin
      width_d[lane_pos(idx_s[1:0], 2'(OFF_WIDTH)) +: 8] = byte_i;
    end else if (stb_i && in_field(idx_s, OFF_HEIGHT, 32'd4)) begin
      height_d[lane_pos(idx_s[1:0], 2'(OFF_HEIGHT)) +: 8] = byte_i;
    end else begin
      sig_d = sig_q;
    end
  end

  // Header shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= 16'd0;
      fsize_q  <= 32'd0;
      doff_q   <= 32'd0;
      width_q  <= 32'd0;
      height_q <= 32'd0;
    end else begin
      sig_q    <= sig_d;
      fsize_q  <= fsize_d;
      doff_q   <= doff_d;
      width_q  <= width_d;
      height_q <= height_d;
    end
  end

  assign sig_o         = sig_q;
  assign file_size_o   = fsize_q;
  assign data_offset_o = doff_q;
  assign width_o       = width_q;
  assign height_o      = height_q;

endmodule

// File: rtl/bmp_load_ctrl.sv
// Sequencing controller for the ROM->RAM BMP byte mover: one request per
// byte, header validation, stall timeout, abort and done/error reporting.
module bmp_load_ctrl
  import bmp_load_ctrl_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TOTAL_SIZE = 1078,
  parameter int HDR_SIZE   = HDR_LEN,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  mv_req,
  input  logic                  mv_rom_valid,
  input  logic [BYTE_WIDTH-1:0] mv_rom_q,
  input  logic                  mv_ram_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic [ADDR_WIDTH-1:0] byte_cnt,
  output logic [31:0]           file_size,
  output logic [31:0]           data_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [2:0]            code_q, code_d;
  logic                  req_q, req_d;
  logic                  hdr_clr_s, hdr_stb_s;
  logic [15:0]           sig_s;

  bmp_hdr_capture #(.ADDR_WIDTH(ADDR_WIDTH)) u_hdr (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (hdr_clr_s),
    .stb_i         (hdr_stb_s),
    .idx_i         (cnt_q),
    .byte_i        (mv_rom_q),
    .sig_o         (sig_s),
    .file_size_o   (file_size),
    .data_offset_o (data_offset),
    .width_o       (img_width),
    .height_o      (img_height)
  );

  // FSM next-state. The request for ISSUE is computed on the way in, so an
  // abort seen at that moment suppresses it without an input->mv_req path.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    code_d    = code_q;
    req_d     = 1'b0;
    hdr_clr_s = 1'b0;
    hdr_stb_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          cnt_d     = {ADDR_WIDTH{1'b0}};
          code_d    = ERR_NONE;
          hdr_clr_s = 1'b1;
          req_d     = !abort;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_d = {TMO_W{1'b0}};
        if (!req_q) begin
          state_d = ST_ERR;
          code_d  = ERR_ABORT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        hdr_stb_s = mv_rom_valid && (cnt_q < ADDR_WIDTH'(HDR_SIZE));
        // A write landing on the last allowed cycle still wins over the timeout.
        if (mv_ram_valid) begin
          cnt_d   = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          state_d = ST_CHECK;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          code_d  = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_ERR;
          code_d  = ERR_ABORT;
        end else if ((cnt_q == ADDR_WIDTH'(2)) && (sig_s != {SIG_B1, SIG_B0})) begin
          state_d = ST_ERR;
          code_d  = ERR_SIG;
        end else if ((cnt_q == ADDR_WIDTH'(HDR_SIZE)) && (file_size != 32'(TOTAL_SIZE))) begin
          state_d = ST_ERR;
          code_d  = ERR_SIZE;
        end else if ((cnt_q == ADDR_WIDTH'(HDR_SIZE)) &&
                     ((data_offset < 32'(HDR_SIZE)) || (data_offset >= 32'(TOTAL_SIZE)))) begin
          state_d = ST_ERR;
          code_d  = ERR_OFFSET;
        end else if (cnt_q == ADDR_WIDTH'(TOTAL_SIZE)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
          req_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state, counters and request strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
      code_q  <= ERR_NONE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      req_q   <= req_d;
    end
  end

  assign mv_req   = req_q;
  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign err_code = code_q;
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_bmp_load_ctrl.sv
// Self-checking bench for bmp_load_ctrl: behavioural mover plus an
// image-level reference model of the load outcome.
module tb_bmp_load_ctrl;

  localparam int N   = 1078;
  localparam int HDR = 54;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start, abort;
  logic          mv_req, mv_rom_valid, mv_ram_valid;
  logic [7:0]    mv_rom_q;
  logic          busy, done, err;
  logic [2:0]    err_code;
  logic [AW-1:0] byte_cnt;
  logic [31:0]   file_size, data_offset, img_width, img_height;

  int tests = 0;
  int fails = 0;
  int nreq, cyc, sc;
  int stall_at = -1;
  int delay_at = -1;
  int delay_n  = 0;

  logic [7:0] rom [0:2047];
  int mv_addr, mv_phase, mv_dcnt;

  bmp_load_ctrl #(.BYTE_WIDTH(8), .ADDR_WIDTH(AW), .TOTAL_SIZE(N), .HDR_SIZE(HDR), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mv_req(mv_req),
    .mv_rom_valid(mv_rom_valid), .mv_rom_q(mv_rom_q), .mv_ram_valid(mv_ram_valid),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .byte_cnt(byte_cnt),
    .file_size(file_size), .data_offset(data_offset), .img_width(img_width), .img_height(img_height)
  );

  always #5 clk = ~clk;

  // Mover: IDLE -> READ -> (optional stretch) -> WRITE; phase 4 is a dead stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_phase <= 0;
      mv_addr  <= 0;
      mv_dcnt  <= 0;
    end else begin
      case (mv_phase)
        0: if (mv_req) mv_phase <= 1;
        1: begin
          if (mv_addr == stall_at) mv_phase <= 4;
          else if (mv_addr == delay_at && delay_n > 0) begin mv_phase <= 2; mv_dcnt <= delay_n; end
          else mv_phase <= 3;
        end
        2: begin
          if (mv_dcnt == 1) mv_phase <= 3;
          mv_dcnt <= mv_dcnt - 1;
        end
        3: begin mv_addr <= mv_addr + 1; mv_phase <= 0; end
        default: mv_phase <= mv_phase;
      endcase
    end
  end

  assign mv_rom_valid = (mv_phase == 1);
  assign mv_ram_valid = (mv_phase == 3);
  assign mv_rom_q     = rom[mv_addr[10:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mv_req) nreq++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    stall_at = -1; delay_at = -1; delay_n = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic put32(input int o, input int unsigned v);
    for (int j = 0; j < 4; j++) rom[o + j] = 8'(v >> (8 * j));
  endtask

  task automatic make_img(input int unsigned fs, input int unsigned off, input int unsigned w,
                          input int unsigned h, input logic [7:0] s0, input logic [7:0] s1);
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[0] = s0; rom[1] = s1;
    put32(2, fs); put32(10, off); put32(18, w); put32(22, h);
  endtask

  // Value of a 4-byte little-endian field, counting only bytes below 'seen'.
  function automatic int unsigned field(input int o, input int seen);
    int unsigned v;
    v = 0;
    for (int j = 0; j < 4; j++)
      if (o + j < seen) v = v + int'(rom[o + j]) * (1 << (8 * j));
    return v;
  endfunction

  // Image-level outcome: walk bytes in order and stop at the first rule that fires.
  function automatic void model(input int stall, input int abrt, output int code,
                                output int cnt, output int reqs, output int cycl);
    code = 0; cnt = 0; reqs = 0; cycl = -1;
    for (int k = 0; k < N; k++) begin
      reqs = k + 1;
      if (k == stall) begin code = 2; cnt = k; cycl = 4 * k + 17; return; end
      cnt = k + 1;
      if (k == abrt) code = 4;
      else if (cnt == 2 && !(rom[0] == 8'h42 && rom[1] == 8'h4D)) code = 1;
      else if (cnt == HDR && field(2, HDR) != N) code = 3;
      else if (cnt == HDR && (field(10, HDR) < HDR || field(10, HDR) >= N)) code = 5;
      else if (cnt == N) code = 0;
      else continue;
      cycl = 4 * cnt + 1;
      return;
    end
  endfunction

  task automatic run_load(input int abort_at, output int stop_cyc);
    int req_cyc;
    req_cyc = -1;
    start = 1'b1; cyc = 0; nreq = 0;
    tick();
    start = 1'b0;
    while (cyc < 8000) begin
      if (done || err) break;
      if (abort_at >= 0 && nreq == abort_at + 1) begin
        if (req_cyc < 0) req_cyc = cyc;
        else if (cyc == req_cyc + 1) abort = 1'b1;
      end
      tick();
    end
    stop_cyc = (done || err) ? cyc : -1;
  endtask

  task automatic outcome(input string nm, input int stall, input int abrt, input int extra, input int stop_cyc);
    int code, cnt, reqs, cycl, seen;
    model(stall, abrt, code, cnt, reqs, cycl);
    seen = (code == 2) ? cnt + 1 : cnt;
    check({nm, "/stop_cycle"}, stop_cyc, cycl + extra);
    check({nm, "/done"}, {31'd0, done}, (code == 0) ? 32'd1 : 32'd0);
    check({nm, "/err"}, {31'd0, err}, (code != 0) ? 32'd1 : 32'd0);
    check({nm, "/err_code"}, {29'd0, err_code}, code);
    check({nm, "/byte_cnt"}, {16'd0, byte_cnt}, cnt);
    check({nm, "/mv_req_count"}, nreq, reqs);
    check({nm, "/busy"}, {31'd0, busy}, 32'd0);
    check({nm, "/file_size"}, file_size, field(2, seen));
    check({nm, "/data_offset"}, data_offset, field(10, seen));
    check({nm, "/img_width"}, img_width, field(18, seen));
    check({nm, "/img_height"}, img_height, field(22, seen));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "/mv_req"}, {31'd0, mv_req}, 32'd0);
    check({nm, "/busy"}, {31'd0, busy}, 32'd0);
    check({nm, "/done"}, {31'd0, done}, 32'd0);
    check({nm, "/err"}, {31'd0, err}, 32'd0);
    check({nm, "/err_code"}, {29'd0, err_code}, 32'd0);
    check({nm, "/byte_cnt"}, {16'd0, byte_cnt}, 32'd0);
    check({nm, "/file_size"}, file_size, 32'd0);
    check({nm, "/data_offset"}, data_offset, 32'd0);
    check({nm, "/img_width"}, img_width, 32'd0);
    check({nm, "/img_height"}, img_height, 32'd0);
  endtask

  initial begin
    int unsigned w, h, off;
    start = 1'b0; abort = 1'b0; cyc = 0; nreq = 0;
    for (int i = 0; i < 2048; i++) rom[i] = 8'd0;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reference image from the test plan.
    make_img(N, HDR, 16, 16, 8'h42, 8'h4D);
    run_load(-1, sc);
    outcome("valid", -1, -1, 0, sc);
    check("valid/fs_const", file_size, 32'd1078);
    check("valid/off_const", data_offset, 32'd54);
    check("valid/wh_const", img_width + img_height, 32'd32);

    // Random dimensions and legal offset.
    do_reset();
    w = $urandom; h = $urandom; off = $urandom_range(N - 1, HDR);
    make_img(N, off, w, h, 8'h42, 8'h4D);
    run_load(-1, sc);
    outcome("rand_valid", -1, -1, 0, sc);

    // Write arriving on the last cycle before timeout must still count.
    do_reset();
    make_img(N, HDR, $urandom, $urandom, 8'h42, 8'h4D);
    delay_at = $urandom_range(N - 1, 0); delay_n = 13;
    run_load(-1, sc);
    outcome("late_write", -1, -1, 13, sc);

    do_reset();
    make_img(N, HDR, 16, 16, 8'h42, 8'h4E);
    run_load(-1, sc);
    outcome("bad_sig", -1, -1, 0, sc);

    do_reset();
    make_img(2000, HDR, 16, 16, 8'h42, 8'h4D);
    run_load(-1, sc);
    outcome("bad_size", -1, -1, 0, sc);

    do_reset();
    off = ($urandom_range(1, 0) == 1) ? $urandom_range(HDR - 1, 0) : $urandom_range(32'hFFFFF, N);
    make_img(N, off, 16, 16, 8'h42, 8'h4D);
    run_load(-1, sc);
    outcome("bad_offset", -1, -1, 0, sc);

    do_reset();
    make_img(N, HDR, 16, 16, 8'h42, 8'h4D);
    stall_at = 9;
    run_load(-1, sc);
    outcome("stall", 9, -1, 0, sc);

    // Abort during WAIT of the 100th byte, then a start pulse in ERR.
    do_reset();
    make_img(N, HDR, 16, 16, 8'h42, 8'h4D);
    run_load(99, sc);
    outcome("abort", -1, 99, 0, sc);
    abort = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("abort/req_after_start", nreq, 32'd100);
    check("abort/still_err", {29'd0, err_code}, 32'd4);

    // Abort already high when start arrives: no request at all.
    do_reset();
    start = 1'b1; abort = 1'b1; cyc = 0; nreq = 0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("idle_abort/err", {31'd0, err}, 32'd1);
    check("idle_abort/err_code", {29'd0, err_code}, 32'd4);
    check("idle_abort/mv_req_count", nreq, 32'd0);

    // Asynchronous reset mid-load, then a fresh load from byte 0.
    do_reset();
    make_img(N, HDR, $urandom, $urandom, 8'h42, 8'h4D);
    start = 1'b1; cyc = 0; nreq = 0;
    tick();
    start = 1'b0;
    while (nreq < 501 && cyc < 3000) tick();
    check("midreset/reached", nreq, 32'd501);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_load(-1, sc);
    outcome("after_reset", -1, -1, 0, sc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
